// File: rtl/instruction_fetch_if.sv
// Instruction-memory bus between the fetch stage and instruction memory.
//   imem_req   : one-cycle request pulse (fetch -> memory)
//   imem_addr  : request address, meaningful only while imem_req=1
//   imem_rdata : returned instruction word (memory -> fetch)
//   imem_valid : imem_rdata valid this cycle
// master = fetch stage, slave = instruction memory.
interface instruction_fetch_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic              imem_valid;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rdata,
        input  imem_valid
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rdata,
        output imem_valid
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage for the ARM-subset processor.
// Holds the PC, issues one instruction-memory request at a time, captures the
// returned word into the instruction register and presents it (plus decoded
// fields) downstream with a valid/stall handshake. A redirect (PCSrc) is only
// honoured in the cycle the presented instruction is consumed.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   imem         : instruction-memory bus (master side)
//   stall        : downstream cannot consume the presented instruction
//   PCSrc/Result : redirect request and target, sampled in the consume cycle
//   instr        : instruction register; instr_valid flags it unconsumed
//   pc_out       : address of instr; PCPlus8 = pc_out + 8 (R15 read value)
//   Cond/Op/Funct/Rn/Rd/Rm : field slices of instr
module instruction_fetch #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master imem,
    input  logic                stall,
    input  logic                PCSrc,
    input  logic [ADDR_W-1:0]   Result,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic [ADDR_W-1:0]   pc_out,
    output logic [ADDR_W-1:0]   PCPlus8,
    output logic [3:0]          Cond,
    output logic [1:0]          Op,
    output logic [5:0]          Funct,
    output logic [3:0]          Rn,
    output logic [3:0]          Rd,
    output logic [3:0]          Rm
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] R15_OFS   = ADDR_W'(8);
    localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] redirect_pc;

    // Redirect targets are forced onto a word boundary.
    assign redirect_pc = Result & WORD_MASK;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        case (state_q)
            IDLE: state_d = REQ;
            REQ:  state_d = WAIT;
            WAIT: begin
                // Only a response in WAIT is accepted; anything else is ignored.
                if (imem.imem_valid) begin
                    instr_d = imem.imem_rdata;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (!stall) begin
                    pc_d    = PCSrc ? redirect_pc : pc_q + PC_STEP;
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;

    assign instr       = instr_q;
    assign instr_valid = (state_q == VALID);
    assign pc_out      = pc_q;
    assign PCPlus8     = pc_q + R15_OFS;

    assign Cond  = instr_q[31:28];
    assign Op    = instr_q[27:26];
    assign Funct = instr_q[25:20];
    assign Rn    = instr_q[19:16];
    assign Rd    = instr_q[15:12];
    assign Rm    = instr_q[3:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed testbench for instruction_fetch. dut0 (RESET_PC=0) exercises boot,
// sequential fetch, stall, branch, wait states and async reset against a
// memory model with programmable latency; dut1 (RESET_PC=FFFFFFFC) checks PC
// wrap against a zero-wait memory.
module tb_instruction_fetch;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        pcsrc;
    logic [31:0] result;
    logic        spur;
    int unsigned mem_delay;

    int n_checks;
    int n_errors;

    instruction_fetch_if #(.ADDR_W(32)) bus0 ();
    instruction_fetch_if #(.ADDR_W(32)) bus1 ();

    logic [31:0] instr0, pc0, pcp8_0;
    logic        iv0;
    logic [3:0]  cond0, rn0, rd0, rm0;
    logic [1:0]  op0;
    logic [5:0]  funct0;

    logic [31:0] instr1, pc1, pcp8_1;
    logic        iv1;
    logic [3:0]  cond1, rn1, rd1, rm1;
    logic [1:0]  op1;
    logic [5:0]  funct1;

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut0 (
        .clk(clk), .rst(rst), .imem(bus0), .stall(stall), .PCSrc(pcsrc), .Result(result),
        .instr(instr0), .instr_valid(iv0), .pc_out(pc0), .PCPlus8(pcp8_0),
        .Cond(cond0), .Op(op0), .Funct(funct0), .Rn(rn0), .Rd(rd0), .Rm(rm0)
    );

    instruction_fetch #(.ADDR_W(32), .RESET_PC(32'hFFFF_FFFC)) dut1 (
        .clk(clk), .rst(rst), .imem(bus1), .stall(1'b0), .PCSrc(1'b0), .Result(32'h0),
        .instr(instr1), .instr_valid(iv1), .pc_out(pc1), .PCPlus8(pcp8_1),
        .Cond(cond1), .Op(op1), .Funct(funct1), .Rn(rn1), .Rd(rd1), .Rm(rm1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory contents: a fixed ADD at 0..C, address-tagged words elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a < 32'h10) return 32'hE081_0002;
        return {8'hE5, a[23:0]};
    endfunction

    // dut0 memory: response arrives mem_delay cycles after the request cycle.
    logic        pend;
    int unsigned cnt;
    logic [31:0] paddr;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend  <= 1'b0;
            cnt   <= 0;
            paddr <= '0;
        end else if (bus0.imem_req) begin
            pend  <= 1'b1;
            cnt   <= mem_delay - 1;
            paddr <= bus0.imem_addr;
        end else if (pend) begin
            if (cnt == 0) pend <= 1'b0;
            else cnt <= cnt - 1;
        end
    end

    assign bus0.imem_valid = spur | (pend && cnt == 0);
    assign bus0.imem_rdata = spur ? 32'hDEAD_BEEF : mem_word(paddr);

    // dut1 memory: zero-wait.
    logic        r1;
    logic [31:0] a1;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            r1 <= 1'b0;
            a1 <= '0;
        end else begin
            r1 <= bus1.imem_req;
            a1 <= bus1.imem_addr;
        end
    end

    assign bus1.imem_valid = r1;
    assign bus1.imem_rdata = mem_word(a1);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        stall     = 1'b0;
        pcsrc     = 1'b0;
        result    = '0;
        spur      = 1'b0;
        mem_delay = 1;
        rst       = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_req",    32'(bus0.imem_req), 32'd0);
        check("rst_iv",     32'(iv0), 32'd0);
        check("rst_instr",  instr0, 32'h0);
        check("rst_pc",     pc0, 32'h0);
        check("rst_pcp8",   pcp8_0, 32'h8);
        check("rst_fields", 32'({cond0, op0, funct0, rn0, rd0, rm0}), 32'h0);
        check("rst_pc_w",   pc1, 32'hFFFF_FFFC);
        check("rst_pcp8_w", pcp8_1, 32'h4);

        rst = 1'b1;                         // cycle 0
        next_cycle();                       // cycle 1: REQ
        check("boot_req",    32'(bus0.imem_req), 32'd1);
        check("boot_addr",   bus0.imem_addr, 32'h0);
        check("wrap_req0",   32'(bus1.imem_req), 32'd1);
        check("wrap_addr0",  bus1.imem_addr, 32'hFFFF_FFFC);
        next_cycle();                       // cycle 2: WAIT
        check("wait_req",    32'(bus0.imem_req), 32'd0);
        check("wait_iv",     32'(iv0), 32'd0);
        next_cycle();                       // cycle 3: VALID
        check("boot_iv",     32'(iv0), 32'd1);
        check("boot_instr",  instr0, 32'hE081_0002);
        check("f_cond",      32'(cond0), 32'hE);
        check("f_op",        32'(op0), 32'h0);
        check("f_funct",     32'(funct0), 32'h08);
        check("f_rn",        32'(rn0), 32'h1);
        check("f_rd",        32'(rd0), 32'h0);
        check("f_rm",        32'(rm0), 32'h2);
        check("boot_pc",     pc0, 32'h0);
        check("boot_pcp8",   pcp8_0, 32'h8);

        next_cycle();                       // cycle 4
        check("seq_req1",    32'(bus0.imem_req), 32'd1);
        check("seq_addr1",   bus0.imem_addr, 32'h4);
        check("wrap_req1",   32'(bus1.imem_req), 32'd1);
        check("wrap_addr1",  bus1.imem_addr, 32'h0);
        repeat (2) next_cycle();            // cycle 6
        check("seq_iv1",     32'(iv0), 32'd1);
        check("seq_pc1",     pc0, 32'h4);
        check("seq_pcp8_1",  pcp8_0, 32'hC);
        next_cycle();                       // cycle 7
        check("seq_req2",    32'(bus0.imem_req), 32'd1);
        check("seq_addr2",   bus0.imem_addr, 32'h8);
        repeat (2) next_cycle();            // cycle 9
        check("seq_iv2",     32'(iv0), 32'd1);
        check("seq_pc2",     pc0, 32'h8);

        // Stall for 5 cycles with a redirect and a spurious response applied.
        for (int i = 0; i < 5; i++) begin
            stall  = 1'b1;
            pcsrc  = 1'b1;
            result = 32'h103;
            spur   = (i == 1);
            check("stall_iv",    32'(iv0), 32'd1);
            check("stall_pc",    pc0, 32'h8);
            check("stall_instr", instr0, 32'hE081_0002);
            check("stall_req",   32'(bus0.imem_req), 32'd0);
            next_cycle();
        end
        spur   = 1'b0;
        stall  = 1'b0;
        pcsrc  = 1'b0;
        result = '0;
        check("stall_end_iv", 32'(iv0), 32'd1);
        check("stall_end_pc", pc0, 32'h8);
        next_cycle();                       // cycle 15
        check("unstall_req",  32'(bus0.imem_req), 32'd1);
        check("unstall_addr", bus0.imem_addr, 32'hC);
        repeat (2) next_cycle();            // cycle 17
        check("seq_pc3",      pc0, 32'hC);
        next_cycle();                       // cycle 18
        check("seq_addr4",    bus0.imem_addr, 32'h10);
        repeat (2) next_cycle();            // cycle 20
        check("br_iv",        32'(iv0), 32'd1);
        check("br_pc",        pc0, 32'h10);
        check("br_instr",     instr0, 32'hE500_0010);

        pcsrc  = 1'b1;
        result = 32'h103;
        next_cycle();                       // cycle 21
        pcsrc  = 1'b0;
        result = '0;
        check("br_req",       32'(bus0.imem_req), 32'd1);
        check("br_addr",      bus0.imem_addr, 32'h100);
        repeat (2) next_cycle();            // cycle 23
        check("br_tgt_iv",    32'(iv0), 32'd1);
        check("br_tgt_pc",    pc0, 32'h100);
        check("br_tgt_instr", instr0, 32'hE500_0100);
        check("br_tgt_pcp8",  pcp8_0, 32'h108);

        // Four-cycle memory latency.
        mem_delay = 4;
        next_cycle();                       // cycle 24
        check("ws_req",       32'(bus0.imem_req), 32'd1);
        check("ws_addr",      bus0.imem_addr, 32'h104);
        for (int k = 0; k < 4; k++) begin
            next_cycle();                   // cycles 25..28
            check("ws_iv_low",  32'(iv0), 32'd0);
            check("ws_req_low", 32'(bus0.imem_req), 32'd0);
        end
        next_cycle();                       // cycle 29
        check("ws_iv",        32'(iv0), 32'd1);
        check("ws_instr",     instr0, 32'hE500_0104);

        next_cycle();                       // cycle 30
        check("rs_req",       32'(bus0.imem_req), 32'd1);
        check("rs_addr",      bus0.imem_addr, 32'h108);
        next_cycle();                       // cycle 31: WAIT
        check("rs_wait_iv",   32'(iv0), 32'd0);

        // Asynchronous reset in the middle of a WAIT cycle.
        #2 rst = 1'b0;
        #1;
        check("ar_iv",        32'(iv0), 32'd0);
        check("ar_req",       32'(bus0.imem_req), 32'd0);
        check("ar_instr",     instr0, 32'h0);
        check("ar_pc",        pc0, 32'h0);
        check("ar_pc_w",      pc1, 32'hFFFF_FFFC);
        mem_delay = 1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        next_cycle();
        check("re_req",       32'(bus0.imem_req), 32'd1);
        check("re_addr",      bus0.imem_addr, 32'h0);
        repeat (2) next_cycle();
        check("re_iv",        32'(iv0), 32'd1);
        check("re_instr",     instr0, 32'hE081_0002);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage for the ARM-subset processor. It holds the program counter, issues one request at a time to instruction memory, and captures the returned word into an instruction register. It presents the decoded fields (Cond, Op, Funct, Rd, Rn, Rm) to the control unit and datapath through a valid/stall handshake. It redirects the PC when the control unit's PCSrc is asserted for the instruction being consumed.

## Interface
- ADDR_W, 32, width of PC and instruction-memory address.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset).
- imem_req  out  1  one-cycle request pulse to instruction memory.
- imem_addr  out  ADDR_W  request address, equal to pc; valid only while imem_req=1.
- imem_rdata  in  32  returned instruction word.
- imem_valid  in  1  imem_rdata valid this cycle; honoured only in WAIT.
- stall  in  1  downstream cannot consume the presented instruction.
- PCSrc  in  1  redirect the PC; sampled only in the consume cycle.
- Result  in  ADDR_W  redirect target; sampled with PCSrc.
- instr  out  32  instruction register.
- instr_valid  out  1  instr holds an unconsumed instruction.
- pc_out  out  ADDR_W  address of instr.
- PCPlus8  out  ADDR_W  pc_out + 8 (R15 read value).
- Cond  out  4  instr[31:28].
- Op  out  2  instr[27:26].
- Funct  out  6  instr[25:20].
- Rn  out  4  instr[19:16].
- Rd  out  4  instr[15:12].
- Rm  out  4  instr[3:0].

## Operation
- Registers: pc (ADDR_W), instr (32), state (2 bits).
- The field outputs and PCPlus8 are combinational slices or sums of these registers. pc_out = pc.
- FSM states:
  - IDLE: entered on reset. Next state is always REQ.
  - REQ: imem_req=1, imem_addr=pc. Next state is always WAIT.
  - WAIT: imem_req=0. When imem_valid=1, instr <= imem_rdata and next state is VALID; otherwise stay in WAIT (no timeout).
  - VALID: instr_valid=1.
    - stall=1: hold instr, pc and state.
    - stall=0 (consume cycle): pc <= PCSrc ? Result : pc+4; next state is REQ.
- Exactly one request is outstanding at a time. imem_valid is ignored in IDLE, REQ and VALID.
- pc arithmetic is modulo 2^ADDR_W. pc+4 and +8 wrap silently: pc=32'hFFFF_FFFC gives next pc 32'h0000_0000.
- Result[1:0] is forced to 00 on redirect (word alignment).
- PCSrc and Result are don't-care outside the consume cycle and never alter pc.
- stall outside VALID has no effect.

## Timing
- Reset (rst=0), asynchronous:
  - state=IDLE, pc=RESET_PC, instr=0.
  - imem_req=0, instr_valid=0.
  - Field outputs are 0; PCPlus8=RESET_PC+8.
- First rising edge with rst=1 moves IDLE→REQ. imem_req is asserted in the following cycle.
- Zero-wait memory (imem_valid one cycle after imem_req):
  - REQ at cycle t, imem_valid at t+1, instr_valid at t+2.
  - If not stalled, next REQ is at t+3, giving a throughput of one instruction per 3 cycles.
  - Each memory wait cycle adds exactly one cycle.
- imem_valid in the same cycle as imem_req is ignored. Memory must respond no earlier than the next cycle.
- Reset mid-operation aborts any outstanding request; the FSM returns to IDLE. Instruction memory must be reset with the same rst so that no stale response arrives after reset.
- The redirect takes effect on the edge ending the consume cycle. The next imem_addr is Result in the following cycle. No wrong-path fetch is ever issued.

## Test plan
- Reset/boot, RESET_PC=0, zero-wait memory, rst released at cycle 0:
  - imem_req=1 with imem_addr=0 at cycle 1.
  - instr_valid=1 at cycle 3 with instr=mem[0].
  - All outputs are 0 (PCPlus8=8) while rst=0.
- Sequential fetch, no stall, memory returns E0810002 at addresses 0, 4, 8:
  - imem_addr sequence is 0, 4, 8, each 3 cycles apart.
  - Fields are Cond=E, Op=00, Funct=08, Rn=1, Rd=0, Rm=2.
- Stall: assert stall for 5 cycles while instr_valid=1.
  - instr, pc_out and instr_valid hold.
  - No imem_req is issued.
  - Next request is to pc+4 in the cycle after stall drops.
- Branch: consume at pc=0x10 with PCSrc=1 and Result=0x103.
  - Next imem_addr=0x100; no request to 0x14.
  - PCSrc=1 while stall=1 has no effect.
- Wait states and spurious valid:
  - Memory delays 4 cycles: instr_valid rises 5 cycles after imem_req.
  - imem_valid pulsed during VALID does not change instr.
- Wrap and async reset:
  - RESET_PC=32'hFFFF_FFFC: the second fetch address is 0.
  - rst asserted during WAIT immediately clears instr_valid and imem_req, and fetch restarts from RESET_PC.
